// File: rtl/sdram_pkg.sv
// Shared SDR SDRAM definitions: command encodings, default timings and the
// command/address bus payload used by the init, refresh, read and write sequencers.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_READ         = 4'b0101;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_MRS          = 4'b0000;

    localparam logic [1:0]  BA_ALL   = 2'b11;
    localparam logic [12:0] ADDR_ALL = 13'h1FFF;

    localparam int unsigned TRP_DEF       = 2;
    localparam int unsigned TRFC_DEF      = 7;
    localparam int unsigned CLK_PERIOD_NS = 10;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } sdram_bus_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval counter and request flag; the request is dropped when the
// controller enters PRECHARGE and re-armed only by the next interval wrap.
module sdram_refresh_timer #(
    parameter int unsigned CNT_REF_MAX = 750
) (
    input  logic sys_clk_i,
    input  logic rst_n_i,
    input  logic init_end,
    input  logic ack,
    output logic auto_refresh_req
);

    localparam int unsigned CNT_W = (CNT_REF_MAX > 1) ? $clog2(CNT_REF_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_REF_MAX - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            cnt              <= '0;
            wrap             <= 1'b0;
            auto_refresh_req <= 1'b0;
        end else begin
            if (!init_end) begin
                cnt  <= '0;
                wrap <= 1'b0;
            end else begin
                wrap <= (cnt == CNT_LAST);
                cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
            // A wrap while still pending simply keeps the flag set.
            if (ack)
                auto_refresh_req <= 1'b0;
            else if (wrap)
                auto_refresh_req <= 1'b1;
        end
    end

endmodule

// File: rtl/sdram_auto_refresh_ctrl.sv
// SDRAM auto-refresh sequencer: requests a refresh every interval and, once
// granted, issues PRECHARGE-ALL followed by AREF_NUM AUTO_REFRESH commands.
module sdram_auto_refresh_ctrl
    import sdram_pkg::*;
#(
    parameter int unsigned CNT_REF_MAX = 750,
    parameter int unsigned TRP         = TRP_DEF,
    parameter int unsigned TRFC        = TRFC_DEF,
    parameter int unsigned AREF_NUM    = 2
) (
    input  logic        sys_clk_i,
    input  logic        rst_n_i,
    input  logic        init_end,
    input  logic        auto_refresh_en,
    output logic        auto_refresh_req,
    output logic        auto_refresh_end,
    output logic [3:0]  auto_refresh_cmd,
    output logic [1:0]  auto_refresh_ba,
    output logic [12:0] auto_refresh_addr
);

    localparam int unsigned WAIT_W = $clog2(max_u(TRP, TRFC) + 1);
    localparam int unsigned AREF_W = $clog2(AREF_NUM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PCH,
        S_WAIT_RP,
        S_AREF,
        S_WAIT_RFC,
        S_END
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [AREF_W-1:0] aref_cnt;
    sdram_bus_t        bus_next, bus_q;
    logic              end_next, end_q;
    logic              pch_entry;

    sdram_refresh_timer #(
        .CNT_REF_MAX (CNT_REF_MAX)
    ) u_timer (
        .sys_clk_i        (sys_clk_i),
        .rst_n_i          (rst_n_i),
        .init_end         (init_end),
        .ack              (pch_entry),
        .auto_refresh_req (auto_refresh_req)
    );

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next state, plus the Moore outputs of that state so they can be registered.
    always_comb begin
        state_next    = state;
        end_next      = 1'b0;
        bus_next.cmd  = CMD_NOP;
        bus_next.ba   = BA_ALL;
        bus_next.addr = ADDR_ALL;
        case (state)
            S_IDLE:     if (auto_refresh_en && init_end) state_next = S_PCH;
            S_PCH:      state_next = S_WAIT_RP;
            S_WAIT_RP:  if (wait_cnt == WAIT_W'(TRP - 1)) state_next = S_AREF;
            S_AREF:     state_next = S_WAIT_RFC;
            S_WAIT_RFC: if (wait_cnt == WAIT_W'(TRFC - 1))
                            state_next = (aref_cnt == AREF_W'(AREF_NUM)) ? S_END : S_AREF;
            S_END:      state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
        case (state_next)
            S_PCH:   bus_next.cmd = CMD_PRECHARGE;
            S_AREF:  bus_next.cmd = CMD_AUTO_REFRESH;
            S_END:   end_next     = 1'b1;
            default: ;
        endcase
    end

    // Request is retired on the same edge that moves the FSM into PCH.
    assign pch_entry = (state == S_IDLE) && (state_next == S_PCH);

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            wait_cnt      <= '0;
            aref_cnt      <= '0;
            bus_q.cmd     <= CMD_NOP;
            bus_q.ba      <= BA_ALL;
            bus_q.addr    <= ADDR_ALL;
            end_q         <= 1'b0;
        end else begin
            wait_cnt <= (state_next != state) ? '0 : wait_cnt + WAIT_W'(1);
            if (state == S_AREF)
                aref_cnt <= aref_cnt + AREF_W'(1);
            else if (state == S_END)
                aref_cnt <= '0;
            bus_q <= bus_next;
            end_q <= end_next;
        end
    end

    assign auto_refresh_cmd  = bus_q.cmd;
    assign auto_refresh_ba   = bus_q.ba;
    assign auto_refresh_addr = bus_q.addr;
    assign auto_refresh_end  = end_q;

endmodule

// File: tb/tb_sdram_auto_refresh_ctrl.sv
// Directed bench for sdram_auto_refresh_ctrl with an echo-grant arbiter stand-in
// and a small SDRAM command-spacing monitor.
module tb_sdram_auto_refresh_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_end;
    logic        en_man;
    logic        req_q = 1'b0;
    int          mode;
    logic        en;
    logic        req;
    logic        done;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    int cyc      = 0;
    int last_pch  = -100;
    int last_aref = -100;

    always #5 clk = ~clk;

    // mode 0: manual grant, 1: request echoed one clock later, 2: grant held high
    assign en = (mode == 1) ? req_q : (mode == 2) ? 1'b1 : en_man;

    always @(posedge clk) req_q <= req;

    sdram_auto_refresh_ctrl dut (
        .sys_clk_i         (clk),
        .rst_n_i           (rst_n),
        .init_end          (init_end),
        .auto_refresh_en   (en),
        .auto_refresh_req  (req),
        .auto_refresh_end  (done),
        .auto_refresh_cmd  (cmd),
        .auto_refresh_ba   (ba),
        .auto_refresh_addr (addr)
    );

    // SDRAM-side spacing rules: tRP after PRECHARGE, tRFC after AUTO_REFRESH.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc = cyc + 1;
            if (cmd == 4'b0001) begin
                if (cyc - last_pch < 3 || cyc - last_aref < 8) viol = viol + 1;
                last_aref = cyc;
            end else if (cmd == 4'b0010) begin
                if (cyc - last_aref < 8) viol = viol + 1;
                last_pch = cyc;
            end else if (cmd != 4'b0111) begin
                viol = viol + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init_end = 1'b0; en_man = 1'b0; mode = 0;
        repeat (10) tick();
        checks += 5;
        if (cmd !== 4'b0111) begin failures++; $display("FAIL reset_cmd got=%b exp=0111", cmd); end
        if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_end got=%b exp=0", done); end
        if (ba !== 2'b11) begin failures++; $display("FAIL reset_ba got=%b exp=11", ba); end
        if (addr !== 13'h1FFF) begin failures++; $display("FAIL reset_addr got=%h exp=1fff", addr); end
    endtask

    task automatic test_no_init();
        int hits = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (req !== 1'b0) hits++;
        end
        checks++;
        if (hits != 0) begin failures++; $display("FAIL no_init_req high_cycles=%0d exp=0", hits); end
    endtask

    task automatic test_sequence();
        int n = 0;
        int lat = 0;
        logic [3:0] exp_cmd [0:20];
        logic       exp_end;
        for (int i = 0; i <= 20; i++) exp_cmd[i] = 4'b0111;
        exp_cmd[0]  = 4'b0010;
        exp_cmd[3]  = 4'b0001;
        exp_cmd[11] = 4'b0001;
        mode = 1;
        init_end = 1'b1;
        while (n < 2000) begin
            tick();
            if (req === 1'b1) break;
            n++;
        end
        checks++;
        if (n != 750) begin failures++; $display("FAIL first_req_latency got=%0d exp=750", n); end
        while (lat < 10) begin
            tick();
            lat++;
            if (cmd === 4'b0010) break;
        end
        checks += 2;
        if (lat != 2) begin failures++; $display("FAIL grant_to_pch got=%0d exp=2", lat); end
        if (req !== 1'b0) begin failures++; $display("FAIL req_in_pch got=%b exp=0", req); end
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) tick();
            exp_end = (i == 19);
            checks++;
            if (cmd !== exp_cmd[i] || done !== exp_end) begin
                failures++;
                $display("FAIL seq_step%0d got cmd=%b end=%b exp cmd=%b end=%b",
                         i, cmd, done, exp_cmd[i], exp_end);
            end
        end
    endtask

    task automatic test_withheld();
        int n = 0;
        int lows = 0;
        int arefs = 0;
        int ends = 0;
        int highs = 0;
        mode = 0; en_man = 1'b0;
        while (n < 1000) begin
            tick();
            if (req === 1'b1) break;
            n++;
        end
        checks++;
        if (n >= 1000) begin failures++; $display("FAIL withheld_req_wait timeout got=%0d exp<1000", n); end
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (req !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin failures++; $display("FAIL withheld_req_drop low_cycles=%0d exp=0", lows); end
        en_man = 1'b1;
        tick();
        en_man = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd === 4'b0001) arefs++;
            if (done === 1'b1) ends++;
            if (req === 1'b1) highs++;
            tick();
        end
        checks += 3;
        if (arefs != 2) begin failures++; $display("FAIL withheld_aref_count got=%0d exp=2", arefs); end
        if (ends != 1) begin failures++; $display("FAIL withheld_end_count got=%0d exp=1", ends); end
        if (highs != 0) begin failures++; $display("FAIL withheld_req_after got=%0d exp=0", highs); end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        int pchs = 0;
        int arefs = 0;
        int ends = 0;
        mode = 2;
        while (lat < 10) begin
            tick();
            lat++;
            if (cmd === 4'b0010) break;
        end
        checks++;
        if (lat >= 10) begin failures++; $display("FAIL b2b_first_pch timeout got=%0d exp<10", lat); end
        for (int i = 0; i < 105; i++) begin
            if (i > 0) tick();
            if (cmd === 4'b0010) pchs++;
            if (cmd === 4'b0001) arefs++;
            if (done === 1'b1) ends++;
        end
        checks += 3;
        if (pchs != 5) begin failures++; $display("FAIL b2b_pch_count got=%0d exp=5", pchs); end
        if (arefs != 10) begin failures++; $display("FAIL b2b_aref_count got=%0d exp=10", arefs); end
        if (ends != 5) begin failures++; $display("FAIL b2b_end_count got=%0d exp=5", ends); end
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        int n = 0;
        int ends = 0;
        int arefs = 0;
        while (lat < 50) begin
            tick();
            lat++;
            if (cmd === 4'b0001) break;
        end
        tick();
        rst_n = 1'b0; mode = 0; en_man = 1'b0;
        tick();
        checks++;
        if (cmd !== 4'b0111 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_cmd got cmd=%b end=%b exp cmd=0111 end=0", cmd, done);
        end
        repeat (3) begin
            tick();
            if (done === 1'b1) ends++;
        end
        rst_n = 1'b1;
        while (n < 2000) begin
            tick();
            if (done === 1'b1) ends++;
            if (cmd === 4'b0001) arefs++;
            if (req === 1'b1) break;
            n++;
        end
        checks += 3;
        if (ends != 0) begin failures++; $display("FAIL reset_mid_end got=%0d exp=0", ends); end
        if (arefs != 0) begin failures++; $display("FAIL reset_mid_aref got=%0d exp=0", arefs); end
        if (n != 750) begin failures++; $display("FAIL reset_mid_req_latency got=%0d exp=750", n); end
    endtask

    initial begin
        test_reset();
        test_no_init();
        test_sequence();
        test_withheld();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (viol != 0) begin failures++; $display("FAIL sdram_timing violations=%0d exp=0", viol); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
